// File: rtl/mux_arbiter.sv
// Two-requester arbitrated mux: round-robin on ties, hold-limited grants,
// one-cycle grant latency and a registered data output.
module mux_arbiter #(
  parameter int WIDTH    = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_a_i,
  input  logic             req_b_i,
  input  logic [WIDTH-1:0] data_a_i,
  input  logic [WIDTH-1:0] data_b_i,
  output logic             gnt_a_o,
  output logic             gnt_b_o,
  output logic             sel_o,
  output logic [WIDTH-1:0] m_o,
  output logic             m_valid_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_A = 2'd1,
    GRANT_B = 2'd2
  } state_e;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_e           state_q, state_d;
  logic [7:0]       hold_cnt_q, hold_cnt_d;
  logic             last_grant_q, last_grant_d;  // 1'b1 = B was granted last
  logic             sel_q, sel_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic             m_valid_q, m_valid_d;
  logic             gnt_a, gnt_b;
  logic             enter_s;

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_a_i && req_b_i) begin
          state_d = last_grant_q ? GRANT_A : GRANT_B;
        end else if (req_a_i) begin
          state_d = GRANT_A;
        end else if (req_b_i) begin
          state_d = GRANT_B;
        end else begin
          state_d = IDLE;
        end
      end
      GRANT_A: begin
        if (!req_a_i) begin
          state_d = req_b_i ? GRANT_B : IDLE;
        end else if (req_b_i && (hold_cnt_q == HOLD_LAST)) begin
          state_d = GRANT_B;
        end else begin
          state_d = GRANT_A;
        end
      end
      GRANT_B: begin
        if (!req_b_i) begin
          state_d = req_a_i ? GRANT_A : IDLE;
        end else if (req_a_i && (hold_cnt_q == HOLD_LAST)) begin
          state_d = GRANT_A;
        end else begin
          state_d = GRANT_B;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Grant decode from the registered state
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    case (state_q)
      GRANT_A: gnt_a = 1'b1;
      GRANT_B: gnt_b = 1'b1;
      default: begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
      end
    endcase
  end

  // Datapath next values: hold counter restarts on every grant entry, incl. A<->B
  always_comb begin
    enter_s      = (state_d != state_q) && (state_d != IDLE);
    hold_cnt_d   = hold_cnt_q;
    last_grant_d = last_grant_q;
    sel_d        = sel_q;
    m_d          = m_q;
    m_valid_d    = 1'b0;
    if (enter_s) begin
      hold_cnt_d   = 8'd0;
      last_grant_d = (state_d == GRANT_B);
    end else if ((state_q != IDLE) && (hold_cnt_q != HOLD_LAST)) begin
      hold_cnt_d = hold_cnt_q + 8'd1;
    end else begin
      hold_cnt_d = hold_cnt_q;
    end
    if (state_d == GRANT_A) begin
      sel_d = 1'b0;
    end else if (state_d == GRANT_B) begin
      sel_d = 1'b1;
    end else begin
      sel_d = sel_q;
    end
    if (gnt_a && req_a_i) begin
      m_d       = data_a_i;
      m_valid_d = 1'b1;
    end else if (gnt_b && req_b_i) begin
      m_d       = data_b_i;
      m_valid_d = 1'b1;
    end else begin
      m_d       = m_q;
      m_valid_d = 1'b0;
    end
  end

  // Datapath registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hold_cnt_q   <= 8'd0;
      last_grant_q <= 1'b1;
      sel_q        <= 1'b0;
      m_q          <= '0;
      m_valid_q    <= 1'b0;
    end else begin
      hold_cnt_q   <= hold_cnt_d;
      last_grant_q <= last_grant_d;
      sel_q        <= sel_d;
      m_q          <= m_d;
      m_valid_q    <= m_valid_d;
    end
  end

  assign gnt_a_o   = gnt_a;
  assign gnt_b_o   = gnt_b;
  assign sel_o     = sel_q;
  assign m_o       = m_q;
  assign m_valid_o = m_valid_q;

endmodule

// File: doc/mux_arbiter.md
MUX_ARBITER -- requirements
Module: mux_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the shared data path width in bits.
REQ-002 The block SHALL have parameter MAX_HOLD, default 8, giving the maximum consecutive grant cycles while the other requester waits (legal range 1..255).
REQ-003 Clock  input  1  single clock for the whole block; the block SHALL have exactly one clock and all flops SHALL update on its rising edge.
REQ-004 Reset  input  1  the block's reset; the block SHALL treat Reset as synchronous and active-high.
REQ-005 req_a  input  1  requester A wants the shared output.
REQ-006 req_b  input  1  requester B wants the shared output.
REQ-007 data_a  input  WIDTH  requester A data.
REQ-008 data_b  input  WIDTH  requester B data.
REQ-009 gnt_a  output  1  A owns the mux this cycle.
REQ-010 gnt_b  output  1  B owns the mux this cycle.
REQ-011 sel  output  1  mux select, 0 = A and 1 = B.
REQ-012 m  output  WIDTH  registered mux output.
REQ-013 m_valid  output  1  m holds data captured under a grant.

Function
REQ-014 The block SHALL use states IDLE, GRANT_A and GRANT_B, with gnt_a = (state==GRANT_A) and gnt_b = (state==GRANT_B), both decoded from registered state.
REQ-015 gnt_a and gnt_b SHALL never be high in the same cycle.
REQ-016 In IDLE, with req_a only, the next state SHALL be GRANT_A; with req_b only, GRANT_B; with no request, IDLE.
REQ-017 In IDLE, with both requests, the next state SHALL be the grant state opposite last_grant, a 1-bit register updated on every grant-state entry.
REQ-018 In GRANT_A, if req_a is low, the next state SHALL be GRANT_B when req_b is high, else IDLE; GRANT_B SHALL behave symmetrically.
REQ-019 In GRANT_A, with req_a high, the next state SHALL be GRANT_B when req_b is high and hold_cnt==MAX_HOLD-1; otherwise GRANT_A; GRANT_B SHALL behave symmetrically.
REQ-020 hold_cnt SHALL be 8 bits wide, load 0 on every grant-state entry (including a direct A<->B switch), increment each cycle in a grant state, and saturate at MAX_HOLD-1.
REQ-021 Grant latency SHALL be one cycle: a request sampled at edge t from IDLE gives gnt high after edge t.
REQ-022 sel SHALL be 0 in GRANT_A and 1 in GRANT_B, and SHALL hold its last value in IDLE.
REQ-023 On each edge where (gnt_a & req_a) or (gnt_b & req_b), m SHALL load the granted requester's data and m_valid SHALL be 1 (one-cycle data latency).
REQ-024 On all other edges, m SHALL hold its value and m_valid SHALL be 0.
REQ-025 With MAX_HOLD=1 and both requests continuously high, the grant SHALL alternate every cycle.

Reset
REQ-026 On an edge with Reset high, the block SHALL set state=IDLE, gnt_a=0, gnt_b=0, sel=0, m=0, m_valid=0, hold_cnt=0 and last_grant=B, so A wins the first tie.
REQ-027 Reset SHALL override all requests, including mid-grant; grants SHALL first reappear one cycle after the first edge with Reset low.

Verification
REQ-028 Reset, then req_a=1 with data_a=4'hA -> gnt_a=1 after edge 1; m=4'hA and m_valid=1 after edge 2; sel=0.
REQ-029 From IDLE after reset, req_a=req_b=1 held for 20 cycles (MAX_HOLD=8) -> A granted 8 cycles, then B 8 cycles, then A; never both grants high.
REQ-030 In GRANT_B with data_b=4'h5, drop req_b while req_a=1 -> the next edge gives gnt_a=1 and sel=0, and m keeps 4'h5 with m_valid=0 on that edge.
REQ-031 In GRANT_A, assert Reset for one cycle -> after that edge, all outputs are 0 and state is IDLE; a simultaneous tie then goes to A.
REQ-032 MAX_HOLD=1 with both requests held -> gnt_a and gnt_b alternate every cycle, and m alternates data_a and data_b one cycle later.
REQ-033 Single requester req_b held 30 cycles with req_a=0 -> gnt_b stays high throughout and hold_cnt saturates with no forced switch.
